// File: rtl/sysctrl_pkg.sv
// Shared command codes, port subcommands and constants for the MCU
// system-control block.
package sysctrl_pkg;

  typedef enum logic [7:0] {
    CMD_STATUS      = 8'd0,
    CMD_LEDS        = 8'd1,
    CMD_COLOR       = 8'd2,
    CMD_BUTTONS     = 8'd3,
    CMD_WRITE       = 8'd4,
    CMD_INT         = 8'd5,
    CMD_PORT_STATUS = 8'd6,
    CMD_PORT_XFER   = 8'd7,
    CMD_MENU        = 8'd8,
    CMD_CFG_READ    = 8'd9
  } cmd_e;

  typedef enum logic [7:0] {
    SUB_INFO  = 8'd0,
    SUB_READ  = 8'd1,
    SUB_WRITE = 8'd2
  } port_sub_e;

  localparam logic [7:0]  MAGIC0       = 8'h5c;
  localparam logic [7:0]  MAGIC1       = 8'h42;
  localparam logic [23:0] NO_MCU_COLOR = 24'h000202;

  // The MCU sends colour bytes LSB-first relative to the core's channel order.
  function automatic logic [7:0] bit_rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/sysctrl_gen_if.sv
// MCU byte-stream link: framed input bytes, registered reply byte, interrupt.
interface sysctrl_gen_if;
  logic       data_in_strobe;
  logic       data_in_start;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       int_out_n;

  modport master (output data_in_strobe, data_in_start, data_in,
                  input  data_out, int_out_n);
  modport slave  (input  data_in_strobe, data_in_start, data_in,
                  output data_out, int_out_n);
endinterface

// File: rtl/sysctrl_cfg_bank.sv
// Bank of 8-bit configuration registers addressed by MCU id byte, with
// reset image load and combinational readback.
module sysctrl_cfg_bank #(
  parameter int                   CFG_NUM     = 32,
  parameter logic [7:0]           CFG_BASE    = 8'h20,
  parameter logic [CFG_NUM*8-1:0] CFG_DEFAULT = '0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_en,
  input  logic [7:0]             wr_id,
  input  logic [7:0]             wr_data,
  input  logic [7:0]             rd_id,
  output logic [7:0]             rd_data,
  output logic                   rd_hit,
  output logic [CFG_NUM*8-1:0]   cfg
);

  function automatic logic mapped(input logic [7:0] id);
    return (32'(id) >= 32'(CFG_BASE)) && (32'(id) < 32'(CFG_BASE) + 32'(CFG_NUM));
  endfunction

  logic [7:0] wr_off;
  logic [7:0] rd_off;

  assign wr_off = wr_id - CFG_BASE;
  assign rd_off = rd_id - CFG_BASE;
  assign rd_hit = mapped(rd_id);

  // Register array: default image on reset, single-byte write on mapped id.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg <= CFG_DEFAULT;
    end else if (wr_en && mapped(wr_id)) begin
      for (int i = 0; i < CFG_NUM; i++)
        if (wr_off == 8'(i)) cfg[8*i +: 8] <= wr_data;
    end
  end

  // Readback mux; caller qualifies with rd_hit.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < CFG_NUM; i++)
      if (rd_off == 8'(i)) rd_data = cfg[8*i +: 8];
  end

endmodule

// File: rtl/sysctrl_gen.sv
// MCU command decoder: turns the framed byte stream into LEDs, colour,
// reset control, config registers, interrupt handling and port transfers.
module sysctrl_gen
  import sysctrl_pkg::*;
#(
  parameter logic [7:0]           CORE_ID       = 8'h00,
  parameter int                   NUM_PORTS     = 1,
  parameter int                   CFG_NUM       = 32,
  parameter logic [7:0]           CFG_BASE      = 8'h20,
  parameter logic [CFG_NUM*8-1:0] CFG_DEFAULT   = '0,
  parameter logic [7:0]           RESET_ID      = "R",
  parameter int unsigned          RESET_TIMEOUT = 80_000_000,
  parameter int                   MENU_AW       = 12
) (
  input  logic                      clk,
  input  logic                      reset_n,
  sysctrl_gen_if.slave              mcu,
  input  logic [7:0]                int_in,
  output logic [7:0]                int_ack,
  input  logic [1:0]                buttons,
  output logic [1:0]                leds,
  output logic [23:0]               color,
  output logic [1:0]                sys_reset,
  output logic [CFG_NUM*8-1:0]      cfg,
  output logic                      cold_boot,
  output logic [MENU_AW-1:0]        menu_addr,
  input  logic [7:0]                menu_data,
  input  logic [NUM_PORTS*32-1:0]   port_status,
  input  logic [NUM_PORTS*8-1:0]    port_out_available,
  input  logic [NUM_PORTS*8-1:0]    port_out_data,
  input  logic [NUM_PORTS*8-1:0]    port_in_available,
  output logic [NUM_PORTS-1:0]      port_out_strobe,
  output logic [NUM_PORTS-1:0]      port_in_strobe,
  output logic [7:0]                port_in_data
);

  logic [7:0]           cmd_q, cnt_q, sub_q, idx_q, id_q, data_out_q;
  logic [31:0]          timeout_q;
  logic                 sys_int;
  logic [NUM_PORTS-1:0] port_avail, avail_q, sel_onehot;
  logic [7:0]           sel_out_data, sel_out_avail, sel_in_avail, stat_byte;
  logic [31:0]          sel_status;
  logic                 sel_valid, cfg_wr_en, cfg_rd_hit;
  logic [7:0]           cfg_rd_data, cfg_rd_byte;

  assign mcu.data_out  = data_out_q;
  assign mcu.int_out_n = ~((|int_in) | sys_int);

  assign cfg_wr_en = mcu.data_in_strobe && !mcu.data_in_start &&
                     cnt_q == 8'd2 && cmd_q == CMD_WRITE;

  sysctrl_cfg_bank #(
    .CFG_NUM     (CFG_NUM),
    .CFG_BASE    (CFG_BASE),
    .CFG_DEFAULT (CFG_DEFAULT)
  ) u_cfg_bank (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (cfg_wr_en),
    .wr_id   (id_q),
    .wr_data (mcu.data_in),
    .rd_id   (id_q),
    .rd_data (cfg_rd_data),
    .rd_hit  (cfg_rd_hit),
    .cfg     (cfg)
  );

  assign cfg_rd_byte = (id_q == RESET_ID) ? {6'b0, sys_reset} :
                       cfg_rd_hit         ? cfg_rd_data : 8'hff;

  // Per-port availability flags and the port picked by the CMD 7 index byte.
  always_comb begin
    port_avail    = '0;
    sel_onehot    = '0;
    sel_out_data  = '0;
    sel_out_avail = '0;
    sel_in_avail  = '0;
    sel_status    = '0;
    stat_byte     = '0;
    stat_byte[0]  = cold_boot;
    for (int i = 0; i < NUM_PORTS; i++) begin
      port_avail[i]  = port_out_available[8*i +: 8] != 8'h00;
      stat_byte[i+1] = port_avail[i];
      if (idx_q == 8'(i)) begin
        sel_onehot[i] = 1'b1;
        sel_out_data  = port_out_data[8*i +: 8];
        sel_out_avail = port_out_available[8*i +: 8];
        sel_in_avail  = port_in_available[8*i +: 8];
        sel_status    = port_status[32*i +: 32];
      end
    end
  end

  assign sel_valid = |sel_onehot;

  // Byte decoder, no-MCU timeout, interrupt latch and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q           <= '0;
      cnt_q           <= '0;
      sub_q           <= '0;
      idx_q           <= '0;
      id_q            <= '0;
      data_out_q      <= '0;
      leds            <= '0;
      color           <= '0;
      sys_reset       <= 2'd3;
      cold_boot       <= 1'b1;
      sys_int         <= 1'b1;
      int_ack         <= '0;
      port_out_strobe <= '0;
      port_in_strobe  <= '0;
      port_in_data    <= '0;
      menu_addr       <= '0;
      timeout_q       <= 32'(RESET_TIMEOUT);
      avail_q         <= '0;
    end else begin
      int_ack         <= '0;
      port_out_strobe <= '0;
      port_in_strobe  <= '0;
      avail_q         <= port_avail;

      if (|(port_avail & ~avail_q)) sys_int <= 1'b1;
      else if (int_ack[0])          sys_int <= 1'b0;

      if (timeout_q != 32'd0) begin
        timeout_q <= timeout_q - 32'd1;
        if (timeout_q == 32'd1) begin
          sys_reset <= 2'd0;
          color     <= NO_MCU_COLOR;
        end
      end

      if (mcu.data_in_strobe && mcu.data_in_start) begin
        cmd_q      <= mcu.data_in;
        cnt_q      <= 8'd1;
        data_out_q <= '0;
        menu_addr  <= '0;
      end else if (mcu.data_in_strobe && cnt_q != 8'd0) begin
        if (cnt_q != 8'hff) cnt_q <= cnt_q + 8'd1;
        data_out_q <= '0;
        case (cmd_q)
          CMD_STATUS: begin
            case (cnt_q)
              8'd1:    data_out_q <= MAGIC0;
              8'd2:    data_out_q <= MAGIC1;
              8'd3:    data_out_q <= CORE_ID;
              8'd4:    data_out_q <= 8'(NUM_PORTS);
              default: ;
            endcase
          end
          CMD_LEDS: if (cnt_q == 8'd1) leds <= mcu.data_in[1:0];
          CMD_COLOR: begin
            case (cnt_q)
              8'd1:    color[15:8]  <= bit_rev8(mcu.data_in);
              8'd2:    color[7:0]   <= bit_rev8(mcu.data_in);
              8'd3:    color[23:16] <= bit_rev8(mcu.data_in);
              default: ;
            endcase
          end
          CMD_BUTTONS: data_out_q <= {6'b0, buttons};
          CMD_WRITE: begin
            if (cnt_q == 8'd1) id_q <= mcu.data_in;
            if (cnt_q == 8'd2 && id_q == RESET_ID) begin
              sys_reset <= mcu.data_in[1:0];
              timeout_q <= '0;
            end
          end
          CMD_INT: begin
            data_out_q <= {int_in[7:1], sys_int};
            if (cnt_q == 8'd1) int_ack <= mcu.data_in;
          end
          CMD_PORT_STATUS: begin
            data_out_q <= stat_byte;
            if (cnt_q == 8'd1) cold_boot <= 1'b0;
          end
          CMD_PORT_XFER: begin
            if (cnt_q == 8'd1) begin
              sub_q      <= mcu.data_in;
              data_out_q <= 8'(NUM_PORTS);
            end else if (cnt_q == 8'd2) begin
              idx_q <= mcu.data_in;
            end else if (sel_valid) begin
              case (sub_q)
                SUB_INFO: begin
                  case (cnt_q)
                    8'd3:    data_out_q <= sel_out_avail;
                    8'd4:    data_out_q <= sel_in_avail;
                    8'd5:    data_out_q <= sel_status[31:24];
                    8'd6:    data_out_q <= sel_status[23:16];
                    8'd7:    data_out_q <= sel_status[15:8];
                    8'd8:    data_out_q <= sel_status[7:0];
                    default: ;
                  endcase
                end
                SUB_READ: begin
                  data_out_q      <= sel_out_data;
                  port_out_strobe <= sel_onehot & {NUM_PORTS{mcu.data_in[0]}};
                end
                SUB_WRITE: begin
                  port_in_data   <= mcu.data_in;
                  port_in_strobe <= sel_onehot;
                end
                default: ;
              endcase
            end
          end
          CMD_MENU: begin
            data_out_q <= menu_data;
            menu_addr  <= menu_addr + MENU_AW'(1);
          end
          CMD_CFG_READ: begin
            if (cnt_q == 8'd1) id_q <= mcu.data_in;
            if (cnt_q == 8'd2) data_out_q <= cfg_rd_byte;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
